priority_decoder: RTL and testbench

Companion to the priority encoder. It consumes the left-most and right-most one-hot masks the encoder produces and rebuilds the contiguous range mask between them, with the right bit as the LSB end and the left bit as the MSB end, inclusive. It also reports both bit indices and flags malformed input. Processing is iterative, one bit position per clock. The block sits downstream of the encoder in the same clock domain and is used to check encoder output or to rebuild a window mask for later stages.

---
 rtl/priority_decoder_if.sv | 27 ++
 rtl/priority_decoder.sv | 153 +++++++++++++++
 tb/tb_priority_decoder.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/priority_decoder_if.sv
// Bus between the priority encoder output stage and the priority decoder.
// The master drives the one-hot masks; the slave returns the rebuilt range.
interface priority_decoder_if #(
    parameter int WIDTH = 7
);
    localparam int IDXW = $clog2(WIDTH);

    logic [WIDTH-1:0] data_left_i;
    logic [WIDTH-1:0] data_right_i;
    logic             data_val_i;
    logic             busy_o;
    logic [WIDTH-1:0] data_o;
    logic [IDXW-1:0]  idx_left_o;
    logic [IDXW-1:0]  idx_right_o;
    logic             error_o;
    logic             data_val_o;

    modport master (
        output data_left_i, data_right_i, data_val_i,
        input  busy_o, data_o, idx_left_o, idx_right_o, error_o, data_val_o
    );

    modport slave (
        input  data_left_i, data_right_i, data_val_i,
        output busy_o, data_o, idx_left_o, idx_right_o, error_o, data_val_o
    );
endinterface

// File: rtl/priority_decoder.sv
// Rebuilds the inclusive range mask between the encoder's right-most and
// left-most one-hot masks, scanning one bit per clock, and flags bad input.
module priority_decoder #(
    parameter int WIDTH = 7
) (
    input logic                clk_i,
    input logic                rst_i,
    priority_decoder_if.slave  bus
);
    localparam int IDXW = $clog2(WIDTH);
    localparam logic [IDXW-1:0] LAST_BIT = IDXW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] left_q, left_d, right_q, right_d;
    logic [WIDTH-1:0] range_q, range_d;
    logic [IDXW-1:0]  cnt_q, cnt_d;
    logic [IDXW-1:0]  l_idx_q, l_idx_d, r_idx_q, r_idx_d;
    logic [1:0]       l_cnt_q, l_cnt_d, r_cnt_q, r_cnt_d;
    logic             l_seen_q, l_seen_d, r_seen_q, r_seen_d;
    logic             busy_q, busy_d, val_q, val_d, error_q, error_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [IDXW-1:0]  idx_left_q, idx_left_d, idx_right_q, idx_right_d;

    logic l_hit, r_hit, empty, err;

    assign l_hit = left_q[cnt_q];
    assign r_hit = right_q[cnt_q];
    // Both masks empty is the encoder's legal "no bits set" case, not an error.
    assign empty = (l_cnt_q == 2'd0) && (r_cnt_q == 2'd0);
    assign err   = !empty && ((l_cnt_q != 2'd1) || (r_cnt_q != 2'd1) || (l_idx_q < r_idx_q));

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d     = state_q;
        left_d      = left_q;
        right_d     = right_q;
        range_d     = range_q;
        cnt_d       = cnt_q;
        l_idx_d     = l_idx_q;
        r_idx_d     = r_idx_q;
        l_cnt_d     = l_cnt_q;
        r_cnt_d     = r_cnt_q;
        l_seen_d    = l_seen_q;
        r_seen_d    = r_seen_q;
        busy_d      = busy_q;
        val_d       = 1'b0;
        error_d     = error_q;
        data_d      = data_q;
        idx_left_d  = idx_left_q;
        idx_right_d = idx_right_q;

        unique case (state_q)
            IDLE: begin
                if (bus.data_val_i) begin
                    left_d   = bus.data_left_i;
                    right_d  = bus.data_right_i;
                    range_d  = '0;
                    cnt_d    = '0;
                    l_idx_d  = '0;
                    r_idx_d  = '0;
                    l_cnt_d  = 2'd0;
                    r_cnt_d  = 2'd0;
                    l_seen_d = 1'b0;
                    r_seen_d = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                if (r_hit) begin
                    r_seen_d = 1'b1;
                    r_idx_d  = cnt_q;
                    if (r_cnt_q != 2'd2) r_cnt_d = r_cnt_q + 2'd1;
                end
                if (l_hit) begin
                    l_idx_d = cnt_q;
                    if (l_cnt_q != 2'd2) l_cnt_d = l_cnt_q + 2'd1;
                end
                // The left bit itself is inside the range; only bits above it are excluded.
                range_d[cnt_q] = (r_seen_q | r_hit) & ~l_seen_q;
                l_seen_d       = l_seen_q | l_hit;
                if (cnt_q == LAST_BIT) state_d = DONE;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            DONE: begin
                val_d   = 1'b1;
                busy_d  = 1'b0;
                error_d = err;
                if (err || empty) begin
                    data_d      = '0;
                    idx_left_d  = '0;
                    idx_right_d = '0;
                end else begin
                    data_d      = range_q;
                    idx_left_d  = l_idx_q;
                    idx_right_d = r_idx_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            left_q      <= '0;
            right_q     <= '0;
            range_q     <= '0;
            cnt_q       <= '0;
            l_idx_q     <= '0;
            r_idx_q     <= '0;
            l_cnt_q     <= 2'd0;
            r_cnt_q     <= 2'd0;
            l_seen_q    <= 1'b0;
            r_seen_q    <= 1'b0;
            busy_q      <= 1'b0;
            val_q       <= 1'b0;
            error_q     <= 1'b0;
            data_q      <= '0;
            idx_left_q  <= '0;
            idx_right_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            left_q      <= left_d;
            right_q     <= right_d;
            range_q     <= range_d;
            cnt_q       <= cnt_d;
            l_idx_q     <= l_idx_d;
            r_idx_q     <= r_idx_d;
            l_cnt_q     <= l_cnt_d;
            r_cnt_q     <= r_cnt_d;
            l_seen_q    <= l_seen_d;
            r_seen_q    <= r_seen_d;
            busy_q      <= busy_d;
            val_q       <= val_d;
            error_q     <= error_d;
            data_q      <= data_d;
            idx_left_q  <= idx_left_d;
            idx_right_q <= idx_right_d;
        end
    end

    assign bus.busy_o      = busy_q;
    assign bus.data_val_o  = val_q;
    assign bus.error_o     = error_q;
    assign bus.data_o      = data_q;
    assign bus.idx_left_o  = idx_left_q;
    assign bus.idx_right_o = idx_right_q;
endmodule

// File: tb/tb_priority_decoder.sv
// Self-checking bench for priority_decoder: directed plan cases plus random
// masks compared against a set-arithmetic reference model.
module tb_priority_decoder;
    localparam int W  = 7;
    localparam int IW = $clog2(W);

    typedef struct packed {
        logic [W-1:0]  data;
        logic [IW-1:0] il;
        logic [IW-1:0] ir;
        logic          err;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [W-1:0] last_data = '0;

    priority_decoder_if #(.WIDTH(W)) bus ();

    priority_decoder #(.WIDTH(W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Range = all bits from right index up to left index, inclusive.
    function automatic exp_t model(input logic [W-1:0] l, input logic [W-1:0] r);
        exp_t e;
        int lc, rc, li, ri;
        longint unsigned m;
        e  = '0;
        lc = $countones(l);
        rc = $countones(r);
        li = 0;
        ri = 0;
        for (int i = 0; i < W; i++) begin
            if (l[i]) li = i;
            if (r[i]) ri = i;
        end
        if (lc == 0 && rc == 0) return e;
        if (lc != 1 || rc != 1 || li < ri) begin
            e.err = 1'b1;
            return e;
        end
        m      = ((64'd1 << (li + 1)) - 64'd1) & ~((64'd1 << ri) - 64'd1);
        e.data = W'(m);
        e.il   = IW'(li);
        e.ir   = IW'(ri);
        return e;
    endfunction

    // Call at a falling edge while idle; returns at the falling edge after the result.
    task automatic run_txn(input logic [W-1:0] l, input logic [W-1:0] r,
                           input bit hold, input string tag);
        exp_t e;
        e = model(l, r);
        bus.data_left_i  = l;
        bus.data_right_i = r;
        bus.data_val_i   = 1'b1;
        @(posedge clk_i);
        for (int k = 0; k <= W + 1; k++) begin
            @(negedge clk_i);
            if (k <= W) begin
                check({tag, "_busy"}, 64'(bus.busy_o), 64'd1);
                check({tag, "_noval"}, 64'(bus.data_val_o), 64'd0);
                if (k == W) check({tag, "_hold"}, 64'(bus.data_o), 64'(last_data));
                bus.data_left_i  = W'($urandom);
                bus.data_right_i = W'($urandom);
                bus.data_val_i   = hold ? 1'b1 : 1'($urandom_range(0, 1));
            end else begin
                check({tag, "_idle"}, 64'(bus.busy_o), 64'd0);
                check({tag, "_val"}, 64'(bus.data_val_o), 64'd1);
                check({tag, "_data"}, 64'(bus.data_o), 64'(e.data));
                check({tag, "_il"}, 64'(bus.idx_left_o), 64'(e.il));
                check({tag, "_ir"}, 64'(bus.idx_right_o), 64'(e.ir));
                check({tag, "_err"}, 64'(bus.error_o), 64'(e.err));
                last_data = e.data;
                if (!hold) bus.data_val_i = 1'b0;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(bus.busy_o), 64'd0);
        check({tag, "_data"}, 64'(bus.data_o), 64'd0);
        check({tag, "_il"}, 64'(bus.idx_left_o), 64'd0);
        check({tag, "_ir"}, 64'(bus.idx_right_o), 64'd0);
        check({tag, "_err"}, 64'(bus.error_o), 64'd0);
        check({tag, "_val"}, 64'(bus.data_val_o), 64'd0);
    endtask

    task automatic rand_masks(output logic [W-1:0] l, output logic [W-1:0] r);
        logic [W-1:0] one;
        int a, b;
        one = 1;
        a   = $urandom_range(0, W - 1);
        b   = $urandom_range(0, W - 1);
        case ($urandom_range(0, 5))
            0: begin
                l = one << ((a > b) ? a : b);
                r = one << ((a > b) ? b : a);
            end
            1: begin
                a = $urandom_range(1, W - 1);
                b = $urandom_range(0, a - 1);
                l = one << b;
                r = one << a;
            end
            2: begin
                l = W'($urandom);
                r = W'($urandom);
            end
            3: begin
                l = '0;
                r = '0;
            end
            4: begin
                l = '0;
                r = one << a;
            end
            default: begin
                l = one << a;
                r = one << a;
            end
        endcase
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] l, r;
        int val_seen;

        bus.data_left_i  = '0;
        bus.data_right_i = '0;
        bus.data_val_i   = 1'b0;
        #2;
        check_all_zero("reset");
        @(negedge clk_i);
        rst_i = 1'b0;

        // Directed plan cases
        run_txn(7'b0100000, 7'b0000100, 1'b0, "normal");
        check("plan_data", 64'(bus.data_o), 64'h3c);
        check("plan_il", 64'(bus.idx_left_o), 64'd5);
        check("plan_ir", 64'(bus.idx_right_o), 64'd2);
        run_txn(7'b0001000, 7'b0001000, 1'b0, "single");
        check("single_lit", 64'(bus.data_o), 64'h08);
        run_txn(7'b0000010, 7'b0100000, 1'b0, "reversed");
        run_txn(7'b0110000, 7'b0000001, 1'b0, "twohot");
        run_txn(7'b0000000, 7'b0000001, 1'b0, "leftzero");
        run_txn(7'b0000000, 7'b0000000, 1'b0, "empty");
        run_txn(7'b1000000, 7'b0000001, 1'b0, "full");

        // Back-to-back with data_val_i held high throughout
        for (int n = 0; n < 6; n++) begin
            rand_masks(l, r);
            run_txn(l, r, 1'b1, "b2b");
        end
        bus.data_val_i = 1'b0;

        // Random masks with random drops while busy
        for (int n = 0; n < 40; n++) begin
            rand_masks(l, r);
            run_txn(l, r, 1'($urandom_range(0, 1)), "rand");
            bus.data_val_i = 1'b0;
        end

        // Async reset mid-scan aborts the transaction
        run_txn(7'b0010000, 7'b0000010, 1'b0, "pre_rst");
        bus.data_left_i  = 7'b0100000;
        bus.data_right_i = 7'b0000001;
        bus.data_val_i   = 1'b1;
        @(posedge clk_i);
        bus.data_val_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1 check_all_zero("async_rst");
        last_data = '0;
        @(negedge clk_i);
        rst_i    = 1'b0;
        val_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_i);
            if (bus.data_val_o) val_seen++;
        end
        check("abort_noval", 64'(val_seen), 64'd0);
        run_txn(7'b0001000, 7'b0000010, 1'b0, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
